// File: rtl/seq_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_gen : Simon Says colour-sequence generator (Galois LFSR + pattern store
//           streamed out over a valid/ready handshake).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module seq_gen #(
   parameter int          MAX_LEN       = 32,
   parameter int          ADV_SHIFTS    = 2,
   parameter logic [31:0] SEED_ZERO_SUB = 32'h0000_0001,
   localparam int         LW            = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   seed,
   input  logic          start,
   input  logic          extend,
   input  logic          play,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    out_color,
   output logic          out_last,
   output logic [LW-1:0] length,
   output logic          full,
   output logic          busy
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int CW = (ADV_SHIFTS > 1) ? $clog2(ADV_SHIFTS) : 1;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXTEND = 2'd1,
      PLAY   = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [31:0]   lfsr;
   logic [31:0]   lfsr_step;
   logic [CW-1:0] cnt;
   logic [AW-1:0] idx;
   logic [1:0]    mem [MAX_LEN];
   logic          last_shift;
   logic          last_step;

   assign lfsr_step  = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);
   assign last_shift = (cnt == CW'(ADV_SHIFTS - 1));
   assign last_step  = (LW'(idx) == (length - LW'(1)));

   assign full      = (length == LW'(MAX_LEN));
   assign busy      = (state != IDLE);
   assign out_valid = (state == PLAY);
   assign out_color = (state == PLAY) ? mem[idx] : 2'b00;
   assign out_last  = (state == PLAY) && last_step;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // start overrides everything and always lands back in IDLE
   always_comb begin
      state_next = state;
      if (start) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (extend && !full)                 state_next = EXTEND;
               else if (play && (length != LW'(0))) state_next = PLAY;
            end
            EXTEND:  if (last_shift)             state_next = IDLE;
            PLAY:    if (out_ready && last_step) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr   <= SEED_ZERO_SUB;
         length <= '0;
         cnt    <= '0;
         idx    <= '0;
      end else if (start) begin
         lfsr   <= (seed == 32'h0) ? SEED_ZERO_SUB : seed;
         length <= '0;
         cnt    <= '0;
         idx    <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               idx <= '0;
            end
            EXTEND: begin
               lfsr <= lfsr_step;
               cnt  <= cnt + CW'(1);
               if (last_shift) length <= length + LW'(1);
            end
            PLAY: begin
               if (out_ready) idx <= idx + AW'(1);
            end
            default: ;
         endcase
      end
   end

   // Store has no reset so it can map onto plain RAM; only length qualifies it.
   always_ff @(posedge clk) begin
      if (!reset && !start && (state == EXTEND) && last_shift)
         mem[length[AW-1:0]] <= lfsr_step[1:0];
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// Directed self-checking bench for seq_gen: reset, extend timing, playback,
// zero-seed substitution, backpressure, saturation and abort.
module tb_seq_gen;

   logic        clk = 1'b0;
   logic        reset, start, extend, play, out_ready;
   logic [31:0] seed;
   logic        out_valid, out_last, full, busy;
   logic [1:0]  out_color;
   logic [5:0]  length;

   int errors = 0;
   int checks = 0;
   int got_n;
   int got_col  [64];
   int got_last [64];

   always #5 clk = ~clk;

   seq_gen dut (
      .clk(clk), .reset(reset), .seed(seed), .start(start), .extend(extend),
      .play(play), .out_valid(out_valid), .out_ready(out_ready),
      .out_color(out_color), .out_last(out_last), .length(length),
      .full(full), .busy(busy)
   );

   function automatic logic [31:0] lstep(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] s);
      seed = s; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // pulse extend and return how many sampled cycles busy stayed high
   task automatic do_extend(output int nbusy);
      extend = 1'b1;
      tick();
      extend = 1'b0;
      nbusy = 0;
      while (busy && nbusy < 20) begin
         nbusy++;
         tick();
      end
   endtask

   task automatic play_collect();
      got_n = 0;
      out_ready = 1'b1;
      play = 1'b1;
      tick();
      play = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (!out_valid || got_n >= 64) break;
         got_col[got_n]  = int'(out_color);
         got_last[got_n] = int'(out_last);
         got_n++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (length !== 6'd0)    begin errors++; $display("FAIL reset_length got=%0d exp=0", length); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (out_color !== 2'd0 || out_last !== 1'b0) begin
         errors++; $display("FAIL reset_color got=%0d/%b exp=0/0", out_color, out_last);
      end
   endtask

   // seed 1: shifts give 80200003, C0300002 | 60180001, B02C0003 | D8360002, 6C1B0001
   task automatic test_extend_play();
      int nb;
      int exp_col [3] = '{2, 3, 1};
      do_start(32'h0000_0001);
      for (int k = 0; k < 3; k++) begin
         do_extend(nb);
         checks++; if (nb != 2) begin errors++; $display("FAIL extend_busy k=%0d got=%0d exp=2", k, nb); end
      end
      checks++; if (length !== 6'd3) begin errors++; $display("FAIL ext_length got=%0d exp=3", length); end
      play_collect();
      checks++; if (got_n != 3) begin errors++; $display("FAIL play_count got=%0d exp=3", got_n); end
      for (int k = 0; k < 3 && k < got_n; k++) begin
         checks++;
         if (got_col[k] != exp_col[k] || got_last[k] != ((k == 2) ? 1 : 0)) begin
            errors++;
            $display("FAIL play_step k=%0d got=%0d/%0d exp=%0d/%0d", k, got_col[k], got_last[k], exp_col[k], (k == 2) ? 1 : 0);
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL play_done_busy got=%b exp=0", busy); end
   endtask

   task automatic test_zero_seed();
      int nb;
      do_start(32'h0000_0000);
      do_extend(nb);
      do_extend(nb);
      for (int r = 0; r < 2; r++) begin
         play_collect();
         checks++;
         if (got_n != 2 || got_col[0] != 2 || got_col[1] != 3 || got_last[0] != 0 || got_last[1] != 1) begin
            errors++;
            $display("FAIL zero_seed_play r=%0d got n=%0d c=%0d,%0d l=%0d,%0d exp n=2 c=2,3 l=0,1",
                     r, got_n, got_col[0], got_col[1], got_last[0], got_last[1]);
         end
      end
   endtask

   task automatic test_backpressure();
      int nb;
      int exp_col [3] = '{2, 3, 1};
      do_start(32'h0000_0001);
      for (int k = 0; k < 3; k++) do_extend(nb);
      out_ready = 1'b0;
      play = 1'b1;
      tick();
      play = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_color !== 2'd2 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold c=%0d got v=%b col=%0d last=%b exp v=1 col=2 last=0", c, out_valid, out_color, out_last);
         end
         tick();
      end
      // alternate ready so each ready cycle moves exactly one step
      got_n = 0;
      for (int c = 0; c < 40; c++) begin
         if (!out_valid || got_n >= 64) break;
         out_ready = c[0];
         if (out_ready) begin
            got_col[got_n]  = int'(out_color);
            got_last[got_n] = int'(out_last);
            got_n++;
         end
         tick();
      end
      out_ready = 1'b1;
      checks++; if (got_n != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", got_n); end
      for (int k = 0; k < 3 && k < got_n; k++) begin
         checks++;
         if (got_col[k] != exp_col[k] || got_last[k] != ((k == 2) ? 1 : 0)) begin
            errors++;
            $display("FAIL bp_step k=%0d got=%0d/%0d exp=%0d", k, got_col[k], got_last[k], exp_col[k]);
         end
      end
   endtask

   task automatic test_full();
      int nb;
      logic [31:0] m;
      int exp_col [32];
      int bad;
      m = 32'h0000_0001;
      for (int k = 0; k < 32; k++) begin
         m = lstep(lstep(m));
         exp_col[k] = int'(m[1:0]);
      end
      do_start(32'h0000_0001);
      for (int k = 0; k < 32; k++) do_extend(nb);
      checks++; if (length !== 6'd32 || full !== 1'b1) begin
         errors++; $display("FAIL full_length got=%0d/%b exp=32/1", length, full);
      end
      do_extend(nb);
      checks++; if (nb != 0 || length !== 6'd32) begin
         errors++; $display("FAIL full_ignore busy=%0d len=%0d exp busy=0 len=32", nb, length);
      end
      play_collect();
      checks++; if (got_n != 32) begin errors++; $display("FAIL full_count got=%0d exp=32", got_n); end
      bad = 0;
      for (int k = 0; k < 32 && k < got_n; k++)
         if (got_col[k] != exp_col[k] || got_last[k] != ((k == 31) ? 1 : 0)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL full_play bad_steps=%0d exp=0", bad); end
   endtask

   task automatic test_abort();
      out_ready = 1'b1;
      play = 1'b1;
      tick();
      play = 1'b0;
      tick(); tick();
      seed = 32'h0000_0001; start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (out_valid !== 1'b0 || length !== 6'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort got v=%b len=%0d busy=%b exp 0/0/0", out_valid, length, busy);
      end
      play = 1'b1;
      tick();
      play = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_play got v=%b busy=%b exp 0/0", out_valid, busy);
      end
      start = 1'b1; extend = 1'b1;
      tick();
      start = 1'b0; extend = 1'b0;
      checks++; if (length !== 6'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL start_extend got len=%0d busy=%b exp 0/0", length, busy);
      end
      tick(); tick();
      checks++; if (length !== 6'd0) begin errors++; $display("FAIL start_extend_late got=%0d exp=0", length); end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; extend = 1'b0; play = 1'b0;
      out_ready = 1'b1; seed = 32'h0;
      #2;
      test_reset();
      test_extend_play();
      test_zero_seed();
      test_backpressure();
      test_full();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
